mrv1_dmem_resp: RTL and testbench



---
 rtl/mrv1_dmem_pkg.sv | 18 +
 rtl/mrv1_dmem_resp_pipe.sv | 31 +++
 rtl/mrv1_dmem_resp.sv | 110 +++++++++++
 tb/tb_mrv1_dmem_resp.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrv1_dmem_pkg.sv
// Shared types and constants for the dmem responder: response payload, LFSR settings, lane count.
package mrv1_dmem_pkg;

  localparam int unsigned DMEM_DATA_WIDTH = 32;
  localparam int unsigned DMEM_BE_WIDTH   = 4;

  localparam int unsigned LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic                       vld;
    logic                       err;
    logic [DMEM_DATA_WIDTH-1:0] data;
  } mrv1_dmem_resp_s;

endpackage

// File: rtl/mrv1_dmem_resp_pipe.sv
// Fixed-depth delay line carrying dmem responses from the accept edge to the response port.
module mrv1_dmem_resp_pipe
  import mrv1_dmem_pkg::*;
#(
  parameter int unsigned LATENCY_P = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  mrv1_dmem_resp_s din,
  output mrv1_dmem_resp_s dout
);

  mrv1_dmem_resp_s stage_q [LATENCY_P];

  // Stage 0 captures on the accept edge; later stages shift one per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY_P); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(LATENCY_P); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[LATENCY_P-1];

endmodule

// File: rtl/mrv1_dmem_resp.sv
// Data-memory responder: byte-enabled word RAM behind a valid/ready request port with fixed-latency in-order responses.
// Optional random request stalling is enabled by defining MRV1_DMEM_STALL_EN.
module mrv1_dmem_resp
  import mrv1_dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P   = 32,
  parameter int unsigned MEM_WORDS_P    = 1024,
  parameter logic [31:0] BASE_ADDR_P    = 32'h0000_0000,
  parameter int unsigned LATENCY_P      = 2,
  parameter int unsigned MAX_OUTST_P    = 4,
  parameter int unsigned OUTST_WIDTH_LP = $clog2(MAX_OUTST_P + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dmem_req_vld_i,
  output logic                     dmem_req_rdy_o,
  input  logic [DATA_WIDTH_P-1:0]  dmem_req_addr_i,
  input  logic                     dmem_req_w_en_i,
  input  logic [DMEM_BE_WIDTH-1:0] dmem_req_w_be_i,
  input  logic [DATA_WIDTH_P-1:0]  dmem_req_w_data_i,
  output logic                     dmem_resp_vld_o,
  output logic [DATA_WIDTH_P-1:0]  dmem_resp_r_data_o,
  output logic                     dmem_resp_err_o
);

  localparam int unsigned IDX_WIDTH = $clog2(MEM_WORDS_P);
  localparam logic [DATA_WIDTH_P:0] MEM_BYTES = (DATA_WIDTH_P + 1)'(MEM_WORDS_P) << 2;

  logic                      accept;
  logic                      in_range;
  logic                      stall;
  logic [DATA_WIDTH_P-1:0]   offset;
  logic [IDX_WIDTH-1:0]      word_idx;
  logic [OUTST_WIDTH_LP-1:0] outst_q;
  logic                      unused_offset_lsbs;
  logic [DATA_WIDTH_P-1:0]   mem [MEM_WORDS_P];
  mrv1_dmem_resp_s           stage0_d;
  mrv1_dmem_resp_s           resp_q;

  // Address decode; the byte offset within a word is irrelevant to a full-word access.
  assign offset             = dmem_req_addr_i - BASE_ADDR_P;
  assign in_range           = {1'b0, offset} < MEM_BYTES;
  assign word_idx           = offset[IDX_WIDTH+1:2];
  assign unused_offset_lsbs = ^offset[1:0];

`ifdef MRV1_DMEM_STALL_EN
  logic [LFSR_WIDTH-1:0] lfsr_q;

  // Free-running LFSR; roughly one cycle in eight withholds ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign stall = (lfsr_q[2:0] == 3'b000);
`else
  assign stall = 1'b0;
`endif

  assign dmem_req_rdy_o = !rst_i && (outst_q < OUTST_WIDTH_LP'(MAX_OUTST_P)) && !stall;
  assign accept         = dmem_req_vld_i && dmem_req_rdy_o;

  // RAM contents survive reset, so the write port has no reset branch.
  always_ff @(posedge clk_i) begin
    if (accept && in_range && dmem_req_w_en_i) begin
      for (int i = 0; i < int'(DMEM_BE_WIDTH); i++) begin
        if (dmem_req_w_be_i[i]) begin
          mem[word_idx][8*i +: 8] <= dmem_req_w_data_i[8*i +: 8];
        end
      end
    end
  end

  // Response payload captured on the accept edge; loads read the pre-edge word.
  always_comb begin
    stage0_d     = '0;
    stage0_d.vld = accept;
    stage0_d.err = accept && !in_range;
    if (accept && in_range && !dmem_req_w_en_i) begin
      stage0_d.data = mem[word_idx];
    end
  end

  mrv1_dmem_resp_pipe #(
    .LATENCY_P (LATENCY_P)
  ) u_pipe (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (stage0_d),
    .dout (resp_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else if (accept && !resp_q.vld) begin
      outst_q <= outst_q + OUTST_WIDTH_LP'(1);
    end else if (!accept && resp_q.vld) begin
      outst_q <= outst_q - OUTST_WIDTH_LP'(1);
    end
  end

  assign dmem_resp_vld_o    = resp_q.vld;
  assign dmem_resp_err_o    = resp_q.err;
  assign dmem_resp_r_data_o = resp_q.data;

endmodule

// File: tb/tb_mrv1_dmem_resp.sv
// Self-checking bench for mrv1_dmem_resp against a byte-array memory model and an expected-response queue.
module tb_mrv1_dmem_resp;

  localparam int unsigned LAT   = 3;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned WORDS = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef MRV1_DMEM_STALL_EN
  localparam bit STALL  = 1'b1;
  localparam int N_RAND = 1000;
`else
  localparam bit STALL  = 1'b0;
  localparam int N_RAND = 300;
`endif

  typedef struct packed {
    bit        idle;
    bit [31:0] addr;
    bit        we;
    bit [3:0]  be;
    bit [31:0] data;
  } req_t;

  typedef struct packed {
    bit        vld;
    bit        err;
    bit        rdy;
    bit        acc;
    bit        zero_out;
    bit [31:0] data;
  } obs_t;

  typedef struct {
    int unsigned due;
    bit          err;
    bit [31:0]   data;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        vld   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rdy;
  logic        rvld;
  logic        rerr;
  logic [31:0] rdata;

  exp_t        exp_q[$];
  bit [7:0]    mem_m [WORDS*4];
  int unsigned cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  mrv1_dmem_resp #(
    .DATA_WIDTH_P (32),
    .MEM_WORDS_P  (WORDS),
    .BASE_ADDR_P  (BASE),
    .LATENCY_P    (LAT),
    .MAX_OUTST_P  (MAXO)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .dmem_req_vld_i     (vld),
    .dmem_req_rdy_o     (rdy),
    .dmem_req_addr_i    (addr),
    .dmem_req_w_en_i    (we),
    .dmem_req_w_be_i    (be),
    .dmem_req_w_data_i  (wdata),
    .dmem_resp_vld_o    (rvld),
    .dmem_resp_r_data_o (rdata),
    .dmem_resp_err_o    (rerr)
  );

  always #5 clk_i = ~clk_i;

  function automatic req_t mk(input bit [31:0] a, input bit w, input bit [3:0] b, input bit [31:0] d);
    req_t r;
    r.idle = 1'b0; r.addr = a; r.we = w; r.be = b; r.data = d;
    return r;
  endfunction

  // Reference behaviour of one accepted request: memory effect now, response LAT cycles later.
  task automatic model_accept(input req_t r, input int unsigned c);
    exp_t        e;
    bit [31:0]   off;
    int unsigned b;
    off    = r.addr - BASE;
    e.due  = c + LAT;
    e.err  = 1'b0;
    e.data = 32'h0;
    if (off >= WORDS * 4) begin
      e.err = 1'b1;
    end else begin
      b = (off / 4) * 4;
      for (int i = 0; i < 4; i++) begin
        if (r.we) begin
          if (r.be[i]) mem_m[b+i] = r.data[8*i +: 8];
        end else begin
          e.data[8*i +: 8] = mem_m[b+i];
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_head(input bit have, input req_t r);
    vld   = have && !r.idle;
    addr  = r.addr;
    we    = r.we;
    be    = r.be;
    wdata = r.data;
  endtask

  // One clock: sample DUT at the falling edge, produce model expectations, advance to just past the rising edge.
  task automatic clk_cycle(output obs_t ob, output obs_t ex);
    req_t r;
    @(negedge clk_i);
    ob.vld = rvld; ob.err = rerr; ob.data = rdata; ob.rdy = rdy; ob.acc = vld && rdy;
    ob.zero_out = 1'b0;
    ex = '0;
    ex.rdy      = !rst_i && (exp_q.size() < MAXO);
    ex.zero_out = (exp_q.size() == 0);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ex.vld  = 1'b1;
      ex.err  = exp_q[0].err;
      ex.data = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    if (ob.acc) begin
      r = mk(addr, we, be, wdata);
      model_accept(r, cyc);
    end
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    obs_t ob, ex;
    @(negedge clk_i);
    tests++;
    if (rdy !== 1'b0 || rvld !== 1'b0 || rerr !== 1'b0 || rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_vals got rdy=%0b vld=%0b err=%0b data=%h want 0 0 0 00000000", rdy, rvld, rerr, rdata);
    end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    clk_cycle(ob, ex);
    tests++;
    if (ob.rdy !== 1'b1 || ob.vld !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got rdy=%0b vld=%0b want rdy=1 vld=0", ob.rdy, ob.vld);
    end
  endtask

  task automatic test_store_load();
    obs_t        ob, ex;
    req_t        rq[$];
    int          guard = 0;
    int unsigned sc, la = 0, lr = 0;
    bit [31:0]   ld = 32'h0;
    bit          le = 1'b1;
    rq = '{mk(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF), mk(BASE + 32'h10, 1'b0, 4'h0, 32'h0)};
    while ((rq.size() > 0 || exp_q.size() > 0) && guard < 100) begin
      if (rq.size() > 0) drive_head(1'b1, rq[0]); else drive_head(1'b0, '0);
      sc = cyc;
      clk_cycle(ob, ex);
      tests++;
      if (ob.vld !== ex.vld || (ex.vld && (ob.data !== ex.data || ob.err !== ex.err)) ||
          (ex.rdy ? (ob.rdy !== 1'b1 && !STALL) : (ob.rdy !== 1'b0))) begin
        fails++;
        $display("FAIL store_load cyc=%0d got vld=%0b err=%0b data=%h rdy=%0b want vld=%0b err=%0b data=%h rdy=%0b",
                 sc, ob.vld, ob.err, ob.data, ob.rdy, ex.vld, ex.err, ex.data, ex.rdy);
      end
      if (ob.acc && !we) la = sc;
      if (ob.vld) begin lr = sc; ld = ob.data; le = ob.err; end
      if (rq.size() > 0 && ob.acc) void'(rq.pop_front());
      guard++;
    end
    tests++;
    if (ld !== 32'hDEAD_BEEF || le !== 1'b0 || lr - la != LAT) begin
      fails++;
      $display("FAIL store_load_word got data=%h err=%0b latency=%0d want data=deadbeef err=0 latency=%0d",
               ld, le, lr - la, LAT);
    end
  endtask

  task automatic test_partial_store();
    obs_t      ob, ex;
    req_t      rq[$];
    int        guard = 0;
    bit [31:0] ld = 32'h0;
    rq = '{mk(BASE + 32'h10, 1'b1, 4'b0010, 32'h0000_AA00), mk(BASE + 32'h10, 1'b0, 4'h0, 32'h0)};
    while ((rq.size() > 0 || exp_q.size() > 0) && guard < 100) begin
      if (rq.size() > 0) drive_head(1'b1, rq[0]); else drive_head(1'b0, '0);
      clk_cycle(ob, ex);
      tests++;
      if (ob.vld !== ex.vld || (ex.vld && (ob.data !== ex.data || ob.err !== ex.err)) ||
          (ex.rdy ? (ob.rdy !== 1'b1 && !STALL) : (ob.rdy !== 1'b0))) begin
        fails++;
        $display("FAIL partial_store cyc=%0d got vld=%0b err=%0b data=%h rdy=%0b want vld=%0b err=%0b data=%h rdy=%0b",
                 cyc - 1, ob.vld, ob.err, ob.data, ob.rdy, ex.vld, ex.err, ex.data, ex.rdy);
      end
      if (ob.vld) ld = ob.data;
      if (rq.size() > 0 && ob.acc) void'(rq.pop_front());
      guard++;
    end
    tests++;
    if (ld !== 32'hDEAD_AAEF) begin
      fails++;
      $display("FAIL partial_store_word got data=%h want deadaaef", ld);
    end
  endtask

  task automatic test_out_of_range();
    obs_t      ob, ex;
    req_t      rq[$];
    int        guard = 0;
    bit [31:0] rd_q[$];
    bit        re_q[$];
    rq = '{mk(BASE + WORDS * 4, 1'b0, 4'h0, 32'h0),
           mk(BASE - 32'h4, 1'b0, 4'h0, 32'h0),
           mk(BASE + WORDS * 4 + 32'h10, 1'b1, 4'hF, 32'h5555_5555),
           mk(BASE + 32'h10, 1'b0, 4'h0, 32'h0),
           mk(BASE + 32'h13, 1'b0, 4'h0, 32'h0)};
    while ((rq.size() > 0 || exp_q.size() > 0) && guard < 100) begin
      if (rq.size() > 0) drive_head(1'b1, rq[0]); else drive_head(1'b0, '0);
      clk_cycle(ob, ex);
      tests++;
      if (ob.vld !== ex.vld || (ex.vld && (ob.data !== ex.data || ob.err !== ex.err)) ||
          (ex.rdy ? (ob.rdy !== 1'b1 && !STALL) : (ob.rdy !== 1'b0))) begin
        fails++;
        $display("FAIL out_of_range cyc=%0d got vld=%0b err=%0b data=%h rdy=%0b want vld=%0b err=%0b data=%h rdy=%0b",
                 cyc - 1, ob.vld, ob.err, ob.data, ob.rdy, ex.vld, ex.err, ex.data, ex.rdy);
      end
      if (ob.vld) begin rd_q.push_back(ob.data); re_q.push_back(ob.err); end
      if (rq.size() > 0 && ob.acc) void'(rq.pop_front());
      guard++;
    end
    tests++;
    if (rd_q.size() != 5 || re_q.size() != 5) begin
      fails++;
      $display("FAIL out_of_range_count got %0d responses want 5", rd_q.size());
    end else if (re_q[0] !== 1'b1 || rd_q[0] !== 32'h0 || re_q[1] !== 1'b1 || re_q[2] !== 1'b1 ||
                 re_q[3] !== 1'b0 || rd_q[3] !== 32'hDEAD_AAEF || re_q[4] !== 1'b0 || rd_q[4] !== 32'hDEAD_AAEF) begin
      fails++;
      $display("FAIL out_of_range_resp got err=%0b%0b%0b%0b%0b d0=%h d3=%h d4=%h want err=11100 d0=00000000 d3=deadaaef d4=deadaaef",
               re_q[0], re_q[1], re_q[2], re_q[3], re_q[4], rd_q[0], rd_q[3], rd_q[4]);
    end
  endtask

  task automatic test_back_to_back();
    obs_t      ob, ex;
    req_t      rq[$];
    int        guard = 0, inflight = 0, max_inflight = 0, bubbles = 0;
    bit [31:0] rd_q[$];
    for (int i = 0; i < 4; i++) rq.push_back(mk(BASE + 32'(4 * (20 + i)), 1'b1, 4'hF, 32'h0101_0101 * 32'(i + 1)));
    for (int i = 0; i < 4; i++) rq.push_back(mk(BASE + 32'(4 * (20 + i)), 1'b0, 4'h0, 32'h0));
    rq.push_back(mk(BASE + 32'(4 * 21), 1'b1, 4'b1001, 32'hAB00_00CD));
    rq.push_back(mk(BASE + 32'(4 * 21), 1'b0, 4'h0, 32'h0));
    while ((rq.size() > 0 || exp_q.size() > 0) && guard < 200) begin
      if (rq.size() > 0) drive_head(1'b1, rq[0]); else drive_head(1'b0, '0);
      clk_cycle(ob, ex);
      tests++;
      if (ob.vld !== ex.vld || (ex.vld && (ob.data !== ex.data || ob.err !== ex.err)) ||
          (ex.rdy ? (ob.rdy !== 1'b1 && !STALL) : (ob.rdy !== 1'b0))) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d got vld=%0b err=%0b data=%h rdy=%0b want vld=%0b err=%0b data=%h rdy=%0b",
                 cyc - 1, ob.vld, ob.err, ob.data, ob.rdy, ex.vld, ex.err, ex.data, ex.rdy);
      end
      if (vld && !ob.rdy) bubbles++;
      if (ob.vld) begin rd_q.push_back(ob.data); inflight--; end
      if (ob.acc) inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
      if (rq.size() > 0 && ob.acc) void'(rq.pop_front());
      guard++;
    end
    tests++;
    if (rd_q.size() != 10 || max_inflight > int'(MAXO) || bubbles == 0) begin
      fails++;
      $display("FAIL back_to_back_flow got resp=%0d max_inflight=%0d bubbles=%0d want resp=10 max_inflight<=%0d bubbles>0",
               rd_q.size(), max_inflight, bubbles, MAXO);
    end else if (rd_q[4] !== 32'h0101_0101 || rd_q[7] !== 32'h0404_0404 || rd_q[9] !== 32'hAB02_02CD) begin
      fails++;
      $display("FAIL back_to_back_order got %h %h %h want 01010101 04040404 ab0202cd", rd_q[4], rd_q[7], rd_q[9]);
    end
  endtask

  task automatic test_reset_inflight();
    obs_t      ob, ex;
    req_t      rq[$];
    int        guard = 0;
    bit [31:0] ld = 32'h0;
    rq = '{mk(BASE + 32'h1C, 1'b1, 4'hF, 32'hCAFE_F00D)};
    while ((rq.size() > 0 || exp_q.size() > 0) && guard < 100) begin
      if (rq.size() > 0) drive_head(1'b1, rq[0]); else drive_head(1'b0, '0);
      clk_cycle(ob, ex);
      if (rq.size() > 0 && ob.acc) void'(rq.pop_front());
      guard++;
    end
    rq = '{mk(BASE + 32'h1C, 1'b0, 4'h0, 32'h0), mk(BASE + 32'h10, 1'b0, 4'h0, 32'h0)};
    while (rq.size() > 0 && guard < 200) begin
      drive_head(1'b1, rq[0]);
      clk_cycle(ob, ex);
      if (ob.acc) void'(rq.pop_front());
      guard++;
    end
    drive_head(1'b0, '0);
    rst_i = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      clk_cycle(ob, ex);
      tests++;
      if (ob.vld !== 1'b0 || ob.rdy !== 1'b0) begin
        fails++;
        $display("FAIL reset_inflight_during got vld=%0b rdy=%0b want vld=0 rdy=0", ob.vld, ob.rdy);
      end
    end
    rst_i = 1'b0;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      clk_cycle(ob, ex);
      tests++;
      if (ob.vld !== 1'b0 || (i == 0 && ob.rdy !== 1'b1)) begin
        fails++;
        $display("FAIL reset_inflight_after i=%0d got vld=%0b rdy=%0b want vld=0 rdy=%0b", i, ob.vld, ob.rdy, i == 0);
      end
    end
    rq = '{mk(BASE + 32'h1C, 1'b0, 4'h0, 32'h0)};
    while ((rq.size() > 0 || exp_q.size() > 0) && guard < 300) begin
      if (rq.size() > 0) drive_head(1'b1, rq[0]); else drive_head(1'b0, '0);
      clk_cycle(ob, ex);
      if (ob.vld) ld = ob.data;
      if (rq.size() > 0 && ob.acc) void'(rq.pop_front());
      guard++;
    end
    tests++;
    if (ld !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL reset_inflight_ram got data=%h want cafef00d", ld);
    end
  endtask

  task automatic test_random();
    obs_t        ob, ex;
    req_t        rq[$];
    req_t        r;
    int          guard = 0, nreq = 0, acc_n = 0, resp_n = 0, stall_zero = 0;
    int unsigned sel;
    for (int w = 0; w < int'(WORDS); w++) rq.push_back(mk(BASE + 32'(4 * w), 1'b1, 4'hF, $urandom));
    nreq = int'(WORDS);
    for (int i = 0; i < N_RAND; i++) begin
      sel = $urandom_range(0, 99);
      r   = mk(BASE + 32'($urandom_range(0, WORDS * 4 - 1)), 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      if (sel < 10) r.addr = BASE + WORDS * 4 + 32'($urandom_range(0, 255));
      else if (sel < 15) r.addr = BASE - 32'($urandom_range(1, 255));
      else if (sel < 30) r.idle = 1'b1;
      if (!r.idle) nreq++;
      rq.push_back(r);
    end
    while ((rq.size() > 0 || exp_q.size() > 0) && guard < 20 * (N_RAND + int'(WORDS))) begin
      if (rq.size() > 0) drive_head(1'b1, rq[0]); else drive_head(1'b0, '0);
      clk_cycle(ob, ex);
      tests++;
      if (ob.vld !== ex.vld || (ex.vld && (ob.data !== ex.data || ob.err !== ex.err)) ||
          (ex.rdy ? (ob.rdy !== 1'b1 && !STALL) : (ob.rdy !== 1'b0))) begin
        fails++;
        $display("FAIL random cyc=%0d got vld=%0b err=%0b data=%h rdy=%0b want vld=%0b err=%0b data=%h rdy=%0b",
                 cyc - 1, ob.vld, ob.err, ob.data, ob.rdy, ex.vld, ex.err, ex.data, ex.rdy);
      end
      if (!ob.rdy && ex.zero_out) stall_zero++;
      if (ob.acc) acc_n++;
      if (ob.vld) resp_n++;
      if (rq.size() > 0 && (ob.acc || rq[0].idle)) void'(rq.pop_front());
      guard++;
    end
    tests++;
    if (rq.size() != 0 || exp_q.size() != 0 || acc_n != nreq || resp_n != nreq) begin
      fails++;
      $display("FAIL random_counts got accepts=%0d responses=%0d left=%0d want accepts=%0d responses=%0d left=0",
               acc_n, resp_n, rq.size() + exp_q.size(), nreq, nreq);
    end
`ifdef MRV1_DMEM_STALL_EN
    tests++;
    if (stall_zero == 0) begin
      fails++;
      $display("FAIL random_stall got %0d stalled idle cycles want >0", stall_zero);
    end
`endif
  endtask

  initial begin
    #1 rst_i = 1'b1;
    test_reset();
    test_store_load();
    test_partial_store();
    test_out_of_range();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
